// File: rtl/dmac_param_fifo.sv
// Single-clock parameterized FIFO with registered read data, level flags,
// per-request ack/err pulses and sticky overflow/underflow history.
module dmac_param_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [DATA_WIDTH-1:0]      d_in,
  output logic [DATA_WIDTH-1:0]      d_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       wr_ack,
  output logic                       wr_err,
  output logic                       rd_ack,
  output logic                       rd_err,
  output logic                       ovf_sticky,
  output logic                       udf_sticky,
  output logic [$clog2(DEPTH):0]     data_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_ok, rd_ok;

  // Accept/reject uses the pre-edge count, so a full FIFO rejects a write
  // even when a read drains a slot in the same cycle (and vice versa at empty).
  assign wr_ok = wr_en && (count != CW'(DEPTH));
  assign rd_ok = rd_en && (count != '0);

  assign data_count   = count;
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // Storage is never cleared; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_ok)
      mem[wr_ptr] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      d_out      <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      wr_ack <= wr_ok;
      wr_err <= wr_en && !wr_ok;
      rd_ack <= rd_ok;
      rd_err <= rd_en && !rd_ok;
      if (wr_en && !wr_ok) ovf_sticky <= 1'b1;
      if (rd_en && !rd_ok) udf_sticky <= 1'b1;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        d_out  <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_param_fifo.sv
// Directed bench: default 16-deep FIFO plus a 4-deep instance for threshold checks.
module tb_dmac_param_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 16-deep instance
  logic        reset, flush, wr_en, rd_en;
  logic [31:0] d_in, d_out;
  logic        full, empty, af, ae, wr_ack, wr_err, rd_ack, rd_err, ovf, udf;
  logic [4:0]  cnt;

  dmac_param_fifo u0 (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
    .d_in(d_in), .d_out(d_out), .full(full), .empty(empty),
    .almost_full(af), .almost_empty(ae), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err), .ovf_sticky(ovf), .udf_sticky(udf),
    .data_count(cnt)
  );

  // 4-deep instance, AF=3, AE=1
  logic        reset1, flush1, wr1, rd1;
  logic [31:0] din1, dout1;
  logic        full1, empty1, af1, ae1, wack1, werr1, rack1, rerr1, ovf1, udf1;
  logic [2:0]  cnt1;

  dmac_param_fifo #(.DATA_WIDTH(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u1 (
    .clk(clk), .reset(reset1), .flush(flush1), .wr_en(wr1), .rd_en(rd1),
    .d_in(din1), .d_out(dout1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .wr_ack(wack1), .wr_err(werr1),
    .rd_ack(rack1), .rd_err(rerr1), .ovf_sticky(ovf1), .udf_sticky(udf1),
    .data_count(cnt1)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] last;

  initial begin
    reset = 1; flush = 0; wr_en = 0; rd_en = 0; d_in = '0;
    reset1 = 1; flush1 = 0; wr1 = 0; rd1 = 0; din1 = '0;
    step();
    reset = 0; reset1 = 0;

    // reset state
    chk("rst_cnt", cnt, 0);   chk("rst_empty", empty, 1); chk("rst_ae", ae, 1);
    chk("rst_full", full, 0); chk("rst_af", af, 0);       chk("rst_dout", d_out, 0);
    chk("rst_pulses", {wr_ack, wr_err, rd_ack, rd_err}, 0);
    chk("rst_sticky", {ovf, udf}, 0);

    // fill 16 words
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; d_in = 32'(i);
      step();
      chk($sformatf("fill_ack%0d", i), wr_ack, 1);
      chk($sformatf("fill_cnt%0d", i), cnt, 64'(i + 1));
      chk($sformatf("fill_af%0d", i), af, (i + 1 >= 14) ? 1 : 0);
      chk($sformatf("fill_full%0d", i), full, (i == 15) ? 1 : 0);
    end

    // overflow
    d_in = 32'h99;
    step();
    chk("ovf_err", wr_err, 1); chk("ovf_ack", wr_ack, 0);
    chk("ovf_sticky", ovf, 1); chk("ovf_cnt", cnt, 16);
    wr_en = 0;
    step();
    chk("ovf_err_1cyc", wr_err, 0); chk("ovf_sticky_hold", ovf, 1);
    chk("idle_pulses", {wr_ack, wr_err, rd_ack, rd_err}, 0);

    // drain in order
    for (int i = 0; i < 16; i++) begin
      rd_en = 1;
      step();
      chk($sformatf("drain_ack%0d", i), rd_ack, 1);
      chk($sformatf("drain_dout%0d", i), d_out, 64'(i));
      chk($sformatf("drain_cnt%0d", i), cnt, 64'(15 - i));
    end
    chk("drain_empty", empty, 1);

    // underflow: d_out holds last read
    step();
    chk("udf_err", rd_err, 1); chk("udf_ack", rd_ack, 0);
    chk("udf_sticky", udf, 1); chk("udf_dout", d_out, 32'h0F);

    // simultaneous rd+wr while empty
    wr_en = 1; d_in = 32'hA5;
    step();
    chk("rw0_wack", wr_ack, 1); chk("rw0_rerr", rd_err, 1);
    chk("rw0_rack", rd_ack, 0); chk("rw0_cnt", cnt, 1);
    chk("rw0_dout", d_out, 32'h0F);
    wr_en = 0;
    step();
    chk("rw0_read", d_out, 32'hA5); chk("rw0_cnt2", cnt, 0);
    rd_en = 0;

    // count=8 then 20 cycles of rd+wr, across pointer wrap
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; d_in = 32'h100 + 32'(i); q.push_back(d_in);
      step();
    end
    chk("steady_cnt0", cnt, 8);
    for (int k = 0; k < 20; k++) begin
      wr_en = 1; rd_en = 1; d_in = 32'h200 + 32'(k); q.push_back(d_in);
      last = q.pop_front();
      step();
      chk($sformatf("steady_dout%0d", k), d_out, last);
      chk($sformatf("steady_cnt%0d", k), cnt, 8);
      chk($sformatf("steady_err%0d", k), {wr_err, rd_err}, 0);
    end
    rd_en = 0;

    // count=10 with stickies set, then flush overriding rd/wr
    d_in = 32'h300; step();
    d_in = 32'h301; step();
    wr_en = 0;
    chk("pre_flush_cnt", cnt, 10); chk("pre_flush_sticky", {ovf, udf}, 2'b11);
    flush = 1; wr_en = 1; rd_en = 1;
    step();
    flush = 0; wr_en = 0; rd_en = 0;
    chk("flush_cnt", cnt, 0); chk("flush_empty", empty, 1);
    chk("flush_sticky", {ovf, udf}, 0);
    chk("flush_pulses", {wr_ack, wr_err, rd_ack, rd_err}, 0);
    chk("flush_dout", d_out, last);

    // after flush, new data is read first
    wr_en = 1; d_in = 32'h77; step();
    wr_en = 0; rd_en = 1; step();
    rd_en = 0;
    chk("post_flush_dout", d_out, 32'h77);

    // reset beats flush and write
    wr_en = 1; d_in = 32'h55; step();
    reset = 1; flush = 1;
    step();
    reset = 0; flush = 0; wr_en = 0;
    chk("rst2_cnt", cnt, 0); chk("rst2_dout", d_out, 0);
    chk("rst2_pulses", {wr_ack, wr_err, rd_ack, rd_err}, 0);
    wr_en = 1; d_in = 32'h66; step();
    wr_en = 0;
    chk("rst2_first_ack", wr_ack, 1); chk("rst2_first_cnt", cnt, 1);

    // 4-deep thresholds
    for (int i = 0; i < 4; i++) begin
      wr1 = 1; din1 = 32'(i);
      step();
      chk($sformatf("d4_cnt%0d", i), cnt1, 64'(i + 1));
      chk($sformatf("d4_ae%0d", i), ae1, (i + 1 <= 1) ? 1 : 0);
      chk($sformatf("d4_af%0d", i), af1, (i + 1 >= 3) ? 1 : 0);
      chk($sformatf("d4_full%0d", i), full1, (i == 3) ? 1 : 0);
    end
    wr1 = 0;
    rd1 = 1; step(); rd1 = 0;
    chk("d4_read0", dout1, 0);

    // reset mid-fill
    reset1 = 1; wr1 = 1; din1 = 32'hEE;
    step();
    reset1 = 0; wr1 = 0;
    chk("d4_rst_cnt", cnt1, 0); chk("d4_rst_flags", {empty1, ae1, full1, af1}, 4'b1100);
    chk("d4_rst_dout", dout1, 0);
    chk("d4_rst_pulses", {wack1, werr1, rack1, rerr1, ovf1, udf1}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/dmac_param_fifo.md
DMAC_PARAM_FIFO -- requirements
Module: dmac_param_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of d_in/d_out.
REQ-002 SHALL have parameter DEPTH, default 16, number of storage words; power of two, 2..256.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port flush  in  1  synchronous clear of contents and sticky errors.
REQ-008 SHALL have port wr_en  in  1  write request.
REQ-009 SHALL have port rd_en  in  1  read request.
REQ-010 SHALL have port d_in  in  DATA_WIDTH  write data.
REQ-011 SHALL have port d_out  out  DATA_WIDTH  registered read data.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty  out  1  level flags.
REQ-013 SHALL have ports wr_ack, wr_err, rd_ack, rd_err  out  1  one-cycle registered pulses.
REQ-014 SHALL have port ovf_sticky, udf_sticky  out  1  latched write-overflow / read-underflow history.
REQ-015 SHALL have port data_count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-016 SHALL store words in circular buffer; wr_ptr/rd_ptr log2(DEPTH) bits, wrap DEPTH-1 -> 0.
REQ-017 SHALL decide accept/reject from data_count at start of cycle (pre-edge value).
REQ-018 Write accepted when wr_en=1 and (count<DEPTH, or count=DEPTH with read accepted same cycle -- not allowed, see REQ-021); accepted write stores d_in at wr_ptr, wr_ptr+1, wr_ack=1 next cycle.
REQ-019 Write rejected when wr_en=1 and count=DEPTH: no storage change, wr_err=1 next cycle, ovf_sticky set.
REQ-020 Read accepted when rd_en=1 and count>0: d_out <= mem[rd_ptr], rd_ptr+1, rd_ack=1 next cycle (latency 1).
REQ-021 Read rejected when rd_en=1 and count=0: d_out held, rd_err=1 next cycle, udf_sticky set.
REQ-022 Simultaneous rd_en&wr_en: count 1..DEPTH-1 -> both accepted, count unchanged; count=0 -> write accepted, read rejected (count -> 1); count=DEPTH -> read accepted, write rejected (count -> DEPTH-1).
REQ-023 data_count SHALL update +1 write-only, -1 read-only, unchanged otherwise; never outside 0..DEPTH.
REQ-024 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL); all derived from registered count.
REQ-025 Ack/err pulses SHALL last exactly one cycle per request; idle cycle -> all four 0.
REQ-026 d_out SHALL hold last read value until next accepted read.
REQ-027 flush=1 SHALL override rd_en/wr_en: pointers and count -> 0, stickies -> 0, ack/err -> 0 next cycle, d_out held, memory contents not cleared.
REQ-028 Sticky flags SHALL remain set until reset or flush.

Reset
REQ-029 reset=1 at rising edge SHALL force: pointers 0, data_count 0, d_out 0, empty 1, almost_empty 1, full 0, almost_full 0, all ack/err 0, stickies 0.
REQ-030 reset SHALL take priority over flush, rd_en, wr_en; reset mid-operation discards all contents; first request accepted the cycle after reset deasserts.

Verification (DEPTH=16, DATA_WIDTH=32 unless noted)
REQ-031 Write 16 words 0x00..0x0F, one per cycle -> 16 wr_ack pulses, full=1, data_count=16, almost_full from count=14.
REQ-032 17th write while full -> wr_err=1 one cycle, ovf_sticky=1, count stays 16; then 16 reads -> d_out 0x00..0x0F in order, rd_ack each, empty=1.
REQ-033 Read while empty -> rd_err=1, udf_sticky=1, d_out unchanged; simultaneous rd+wr while empty with d_in=0xA5 -> wr_ack, rd_err, count=1.
REQ-034 Count=8, rd_en&wr_en for 20 cycles -> count stays 8, pointers wrap, data order preserved, no errors.
REQ-035 Count=10 with stickies set, flush=1 with rd_en=wr_en=1 -> count=0, empty=1, stickies 0, no ack/err next cycle.
REQ-036 DEPTH=4, AF_LEVEL=3, AE_LEVEL=1: fill -> almost_empty clears at count 2, almost_full sets at 3, full at 4; reset mid-fill -> all outputs to REQ-029 values.
